// File: rtl/servo_sequencer.sv
// servo_sequencer: slew-limited drop cycle (ramp up, hold, ramp down, done) feeding the servo PWM width.
// Define SERVO_SEQ_ABORT_EN to add the abort input (early ramp-down from RAMP_UP/HOLD).
module servo_sequencer #(
    parameter int WIDTH      = 21,
    parameter int MIN_W      = 100000,
    parameter int MAX_W      = 200000,
    parameter int STEP       = 1000,
    parameter int STEP_TICKS = 100000,
    parameter int HOLD_TICKS = 50000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             servo_flag,
`ifdef SERVO_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic [WIDTH-1:0] servo_duty,
    output logic             busy,
    output logic             done
);
    localparam int MAX_T = (STEP_TICKS > HOLD_TICKS) ? STEP_TICKS : HOLD_TICKS;
    localparam int TW    = (MAX_T > 2) ? $clog2(MAX_T) : 1;
    localparam logic [WIDTH-1:0] LO = WIDTH'(MIN_W);
    localparam logic [WIDTH-1:0] HI = WIDTH'(MAX_W);
    localparam logic [WIDTH-1:0] ST = WIDTH'(STEP);
    localparam logic [TW-1:0] STEP_END = TW'(STEP_TICKS - 1);
    localparam logic [TW-1:0] HOLD_END = TW'(HOLD_TICKS - 1);

    typedef enum logic [2:0] {IDLE, RAMP_UP, HOLD, RAMP_DOWN, DONE} state_t;

    state_t          state;
    logic [TW-1:0]   tick;
    logic            flag_q;
    logic            start;
    logic            abort_req;
    logic [WIDTH-1:0] up_duty;
    logic [WIDTH-1:0] dn_duty;

    assign start = servo_flag & ~flag_q;
    // Saturating steps: compare the remaining distance first so the sum/difference never wraps.
    assign up_duty = (HI - servo_duty <= ST) ? HI : servo_duty + ST;
    assign dn_duty = (servo_duty - LO <= ST) ? LO : servo_duty - ST;
`ifdef SERVO_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            servo_duty <= LO;
            busy       <= 1'b0;
            done       <= 1'b0;
            tick       <= '0;
            flag_q     <= 1'b0;
        end else begin
            flag_q <= servo_flag;
            done   <= state == DONE;
            busy   <= (state != IDLE) | start;
            case (state)
                IDLE: begin
                    servo_duty <= LO;
                    tick       <= '0;
                    if (start) state <= RAMP_UP;
                end
                RAMP_UP: begin
                    if (abort_req) begin
                        state <= RAMP_DOWN;
                        tick  <= '0;
                    end else if (tick == STEP_END) begin
                        tick       <= '0;
                        servo_duty <= up_duty;
                        if (up_duty == HI) state <= HOLD;
                    end else tick <= tick + 1'b1;
                end
                HOLD: begin
                    if (abort_req || tick == HOLD_END) begin
                        state <= RAMP_DOWN;
                        tick  <= '0;
                    end else tick <= tick + 1'b1;
                end
                RAMP_DOWN: begin
                    if (tick == STEP_END) begin
                        tick       <= '0;
                        servo_duty <= dn_duty;
                        if (dn_duty == LO) state <= DONE;
                    end else tick <= tick + 1'b1;
                end
                DONE: begin
                    servo_duty <= LO;
                    tick       <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_servo_sequencer.sv
// tb_servo_sequencer: directed checks of the drop cycle on a STEP=10 and a STEP=25 instance.
module tb_servo_sequencer;
    logic clk = 1'b0;
    logic reset, flag;
`ifdef SERVO_SEQ_ABORT_EN
    logic abort;
`endif
    logic [20:0] duty0, duty1;
    logic busy0, busy1, done0, done1;
    int errors = 0, checks = 0;
    int dn0, dn1, mn1, mx1;

    always #5 clk = ~clk;

    servo_sequencer #(.WIDTH(21), .MIN_W(10), .MAX_W(40), .STEP(10), .STEP_TICKS(4), .HOLD_TICKS(8)) d0 (
        .clk(clk), .reset(reset), .servo_flag(flag),
`ifdef SERVO_SEQ_ABORT_EN
        .abort(abort),
`endif
        .servo_duty(duty0), .busy(busy0), .done(done0));

    servo_sequencer #(.WIDTH(21), .MIN_W(10), .MAX_W(40), .STEP(25), .STEP_TICKS(4), .HOLD_TICKS(8)) d1 (
        .clk(clk), .reset(reset), .servo_flag(flag),
`ifdef SERVO_SEQ_ABORT_EN
        .abort(abort),
`endif
        .servo_duty(duty1), .busy(busy1), .done(done1));

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        flag  = 1'b0;
`ifdef SERVO_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) step();
        check("rst_duty", int'(duty0), 10);
        check("rst_busy", int'(busy0), 0);
        check("rst_done", int'(done0), 0);
        reset = 1'b0;
        step();
        // Full cycle with flag held high throughout: one done pulse, no retrigger.
        flag = 1'b1;
        dn0 = 0; dn1 = 0; mn1 = 1000; mx1 = 0;
        for (int n = 1; n <= 45; n++) begin
            step();
            dn0 += int'(done0);
            dn1 += int'(done1);
            if (int'(duty1) < mn1) mn1 = int'(duty1);
            if (int'(duty1) > mx1) mx1 = int'(duty1);
            case (n)
                1:  check("busy_c1", int'(busy0), 1);
                4:  check("duty_c4", int'(duty0), 10);
                5:  check("duty_c5", int'(duty0), 20);
                9:  check("duty_c9", int'(duty0), 30);
                12: check("duty_c12", int'(duty0), 30);
                13: check("duty_c13", int'(duty0), 40);
                21: check("duty_c21", int'(duty0), 40);
                25: check("duty_c25", int'(duty0), 30);
                29: check("duty_c29", int'(duty0), 20);
                33: begin check("duty_c33", int'(duty0), 10); check("done_c33", int'(done0), 0); end
                34: begin check("done_c34", int'(done0), 1); check("busy_c34", int'(busy0), 1); end
                35: begin check("done_c35", int'(done0), 0); check("busy_c35", int'(busy0), 0); end
                default: ;
            endcase
            case (n)
                5:  check("s25_c5", int'(duty1), 35);
                9:  check("s25_c9", int'(duty1), 40);
                21: check("s25_c21", int'(duty1), 15);
                25: check("s25_c25", int'(duty1), 10);
                26: check("s25_done_c26", int'(done1), 1);
                default: ;
            endcase
        end
        check("held_done_cnt", dn0, 1);
        check("held_busy_end", int'(busy0), 0);
        check("s25_done_cnt", dn1, 1);
        check("s25_min", mn1, 10);
        check("s25_max", mx1, 40);
        // Second rising edge during HOLD must be discarded.
        flag = 1'b0;
        step();
        step();
        flag = 1'b1;
        dn0 = 0;
        for (int n = 1; n <= 40; n++) begin
            step();
            dn0 += int'(done0);
            if (n == 15) flag = 1'b0;
            if (n == 16) flag = 1'b1;
            if (n == 34) check("reedge_done_c34", int'(done0), 1);
        end
        check("reedge_done_cnt", dn0, 1);
        check("reedge_idle", int'(busy0), 0);
        flag = 1'b0;
        step();
        flag = 1'b1;
        step();
        check("restart_busy", int'(busy0), 1);
        repeat (4) step();
        check("restart_duty", int'(duty0), 20);
        // Reset in the middle of RAMP_UP.
        reset = 1'b1;
        flag  = 1'b0;
        step();
        check("midrst_duty", int'(duty0), 10);
        check("midrst_busy", int'(busy0), 0);
        check("midrst_done", int'(done0), 0);
        step();
        step();
        reset = 1'b0;
        step();
        check("postrst_busy", int'(busy0), 0);
        check("postrst_duty", int'(duty0), 10);
`ifdef SERVO_SEQ_ABORT_EN
        flag = 1'b1;
        dn0 = 0;
        for (int n = 1; n <= 25; n++) begin
            step();
            dn0 += int'(done0);
            if (n == 9) begin
                check("abort_pre", int'(duty0), 30);
                abort = 1'b1;
            end
            if (n == 10) begin
                abort = 1'b0;
                check("abort_c10", int'(duty0), 30);
            end
            if (n == 13) check("abort_c13", int'(duty0), 30);
            if (n == 14) check("abort_c14", int'(duty0), 20);
            if (n == 18) check("abort_c18", int'(duty0), 10);
            if (n == 19) check("abort_done_c19", int'(done0), 1);
        end
        check("abort_done_cnt", dn0, 1);
        check("abort_idle", int'(busy0), 0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
